fifo_ctrl_8_8: RTL and testbench

FIFO_CTRL_8_8 -- requirements
Module: fifo_ctrl_8_8

---
 rtl/fifo_ctrl_8_8.sv | 127 ++++++++++++
 tb/tb_fifo_ctrl_8_8.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl_8_8.sv
// ============================================================================
//  Module   : fifo_ctrl_8_8
//  Brief    : Single-clock FIFO controller driving an external synchronous RAM.
//             Optional sticky overflow/underflow flags: FIFO_CTRL_ERR_STICKY_EN
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_ctrl_8_8 #(
    parameter int ADDR   = 3,
    parameter int WORDS  = 8,
    parameter int AF_LVL = 6
) (
    input  logic            fctl_clk,
    input  logic            fctl_rst,
    input  logic            fctl_push,
    input  logic            fctl_pop,
    input  logic            fctl_clr_err,
    output logic            mem_wen,
    output logic [ADDR-1:0] mem_waddr,
    output logic [ADDR-1:0] mem_raddr,
    output logic            fctl_rvld,
    output logic [ADDR:0]   fctl_cnt,
    output logic            fctl_full,
    output logic            fctl_empty,
    output logic            fctl_afull,
    output logic            fctl_ovf,
    output logic            fctl_udf
);

    localparam logic [ADDR:0] c_words  = (ADDR + 1)'(WORDS);
    localparam logic [ADDR:0] c_af_lvl = (ADDR + 1)'(AF_LVL);

    logic [ADDR-1:0] wptr_q, wptr_d;
    logic [ADDR-1:0] rptr_q, rptr_d;
    logic [ADDR:0]   cnt_q,  cnt_d;
    logic            rvld_q;
    logic            w_push_acc;
    logic            w_pop_acc;

    assign fctl_full  = (cnt_q == c_words);
    assign fctl_empty = (cnt_q == '0);
    assign fctl_afull = (cnt_q >= c_af_lvl);

    // A pop frees a slot in the same cycle, so a full FIFO still takes a push.
    assign w_pop_acc  = fctl_pop & ~fctl_empty;
    assign w_push_acc = fctl_push & (~fctl_full | w_pop_acc);

    assign mem_wen   = w_push_acc & ~fctl_rst;
    assign mem_waddr = wptr_q;
    assign mem_raddr = rptr_q;
    assign fctl_rvld = rvld_q;
    assign fctl_cnt  = cnt_q;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (w_push_acc) begin
            wptr_d = wptr_q + ADDR'(1);
        end
        if (w_pop_acc) begin
            rptr_d = rptr_q + ADDR'(1);
        end
        if (w_push_acc && !w_pop_acc) begin
            cnt_d = cnt_q + (ADDR + 1)'(1);
        end else if (w_pop_acc && !w_push_acc) begin
            cnt_d = cnt_q - (ADDR + 1)'(1);
        end
    end

    always_ff @(posedge fctl_clk) begin
        if (fctl_rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            rvld_q <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            rvld_q <= w_pop_acc;
        end
    end

`ifdef FIFO_CTRL_ERR_STICKY_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    // Setting wins over a simultaneous clear so no error event is lost.
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (fctl_push && !w_push_acc) begin
            ovf_d = 1'b1;
        end else if (fctl_clr_err) begin
            ovf_d = 1'b0;
        end
        if (fctl_pop && !w_pop_acc) begin
            udf_d = 1'b1;
        end else if (fctl_clr_err) begin
            udf_d = 1'b0;
        end
    end

    always_ff @(posedge fctl_clk) begin
        if (fctl_rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign fctl_ovf = ovf_q;
    assign fctl_udf = udf_q;
`else
    logic unused_clr_err;
    assign unused_clr_err = fctl_clr_err;
    assign fctl_ovf       = 1'b0;
    assign fctl_udf       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_ctrl_8_8.sv
// ============================================================================
//  Module   : tb_fifo_ctrl_8_8
//  Brief    : Self-checking bench for fifo_ctrl_8_8 with a behavioural RAM,
//             a queue reference model and a read-data scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fifo_ctrl_8_8;

    logic       fctl_clk = 1'b0;
    logic       fctl_rst = 1'b1;
    logic       fctl_push = 1'b0;
    logic       fctl_pop = 1'b0;
    logic       fctl_clr_err = 1'b0;
    logic       mem_wen;
    logic [2:0] mem_waddr;
    logic [2:0] mem_raddr;
    logic       fctl_rvld;
    logic [3:0] fctl_cnt;
    logic       fctl_full;
    logic       fctl_empty;
    logic       fctl_afull;
    logic       fctl_ovf;
    logic       fctl_udf;

    always #5 fctl_clk = ~fctl_clk;

    fifo_ctrl_8_8 #(.ADDR(3), .WORDS(8), .AF_LVL(6)) dut (
        .fctl_clk     (fctl_clk),
        .fctl_rst     (fctl_rst),
        .fctl_push    (fctl_push),
        .fctl_pop     (fctl_pop),
        .fctl_clr_err (fctl_clr_err),
        .mem_wen      (mem_wen),
        .mem_waddr    (mem_waddr),
        .mem_raddr    (mem_raddr),
        .fctl_rvld    (fctl_rvld),
        .fctl_cnt     (fctl_cnt),
        .fctl_full    (fctl_full),
        .fctl_empty   (fctl_empty),
        .fctl_afull   (fctl_afull),
        .fctl_ovf     (fctl_ovf),
        .fctl_udf     (fctl_udf)
    );

    // Synchronous RAM with read-before-write on a shared address.
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic [7:0] mem [0:7];

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    end

    always @(posedge fctl_clk) begin
        if (mem_wen) mem[mem_waddr] <= wdata;
        rdata <= mem[mem_raddr];
    end

    int checks   = 0;
    int failures = 0;

    logic [7:0] q[$];
    logic [7:0] sb[$];
    int         m_wp = 0, m_rp = 0;
    bit         m_rvld = 0, m_ovf = 0, m_udf = 0;

    bit         p_rst, p_push, p_pop, p_clr, p_push_ok, p_pop_ok;
    logic [7:0] p_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit p, input bit o, input bit c, input logic [7:0] d);
        @(negedge fctl_clk);
        fctl_rst = r; fctl_push = p; fctl_pop = o; fctl_clr_err = c; wdata = d;
        p_rst = r; p_push = p; p_pop = o; p_clr = c; p_data = d;
        p_pop_ok  = o && (q.size() > 0);
        p_push_ok = p && ((q.size() < 8) || p_pop_ok);
        #1;
        chk("mem_wen", mem_wen, (p_push_ok && !r));
        if (!r) begin
            chk("mem_waddr", mem_waddr, m_wp);
            chk("mem_raddr", mem_raddr, m_rp);
        end
    endtask

    task automatic finish_cyc();
        @(posedge fctl_clk);
        if (p_rst) begin
            q.delete(); sb.delete();
            m_wp = 0; m_rp = 0; m_rvld = 0; m_ovf = 0; m_udf = 0;
        end else begin
            if (p_pop_ok) begin
                sb.push_back(q.pop_front());
                m_rp = (m_rp + 1) % 8;
            end
            if (p_push_ok) begin
                q.push_back(p_data);
                m_wp = (m_wp + 1) % 8;
            end
            m_rvld = p_pop_ok;
`ifdef FIFO_CTRL_ERR_STICKY_EN
            if (p_push && !p_push_ok) m_ovf = 1; else if (p_clr) m_ovf = 0;
            if (p_pop && !p_pop_ok)   m_udf = 1; else if (p_clr) m_udf = 0;
`endif
        end
        #1;
        chk("cnt",   fctl_cnt,   q.size());
        chk("full",  fctl_full,  (q.size() == 8));
        chk("empty", fctl_empty, (q.size() == 0));
        chk("afull", fctl_afull, (q.size() >= 6));
        chk("rvld",  fctl_rvld,  m_rvld);
        chk("ovf",   fctl_ovf,   m_ovf);
        chk("udf",   fctl_udf,   m_udf);
        if (m_rvld && sb.size() > 0) chk("rdata", rdata, sb.pop_front());
    endtask

    task automatic cyc(input bit r, input bit p, input bit o, input bit c, input logic [7:0] d);
        drive(r, p, o, c, d);
        finish_cyc();
    endtask

    typedef struct {
        bit         push;
        bit         pop;
        logic [7:0] data;
        int         cnt;
        bit         full;
        bit         empty;
        bit         afull;
        bit         wen;
        int         waddr;
    } vec_t;

    vec_t tbl[16];

    initial begin
        // Eight pushes of 0x11..0x88 then eight pops draining the FIFO.
        for (int i = 0; i < 8; i++) begin
            tbl[i]     = '{1'b1, 1'b0, 8'((i + 1) * 8'h11), i + 1,
                           (i == 7), 1'b0, (i + 1 >= 6), 1'b1, i};
            tbl[i + 8] = '{1'b0, 1'b1, 8'h00, 7 - i,
                           1'b0, (i == 7), (7 - i >= 6), 1'b0, 0};
        end

        cyc(1, 0, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 8'h00);
        chk("rst_empty", fctl_empty, 1);
        chk("rst_full",  fctl_full,  0);

        for (int i = 0; i < 16; i++) begin
            drive(0, tbl[i].push, tbl[i].pop, 0, tbl[i].data);
            chk("tbl_wen", mem_wen, tbl[i].wen);
            if (tbl[i].push) chk("tbl_waddr", mem_waddr, tbl[i].waddr);
            finish_cyc();
            chk("tbl_cnt",   fctl_cnt,   tbl[i].cnt);
            chk("tbl_full",  fctl_full,  tbl[i].full);
            chk("tbl_empty", fctl_empty, tbl[i].empty);
            chk("tbl_afull", fctl_afull, tbl[i].afull);
        end

        // Push on full without pop, then clear the sticky flag.
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 8'hA0 + 8'(i));
        cyc(0, 1, 0, 0, 8'hEE);
        chk("ovf_full_push_cnt", fctl_cnt, 8);
        cyc(0, 0, 0, 1, 8'h00);

        // Simultaneous push and pop on full: count holds, old word returned.
        cyc(0, 1, 1, 0, 8'h5A);
        cyc(0, 1, 1, 0, 8'h5B);
        chk("full_pp_cnt", fctl_cnt, 8);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, 8'h00);

        // Push and pop on empty: only the push lands.
        cyc(0, 1, 1, 0, 8'h77);
        chk("empty_pp_cnt",  fctl_cnt,  1);
        chk("empty_pp_rvld", fctl_rvld, 0);
        cyc(0, 0, 0, 1, 8'h00);
        cyc(0, 0, 1, 0, 8'h00);

        // Pointer wrap with data integrity across 12 push/pop pairs.
        cyc(1, 0, 0, 0, 8'h00);
        cyc(0, 1, 0, 0, 8'hC0);
        for (int i = 0; i < 12; i++) cyc(0, 1, 1, 0, 8'hC1 + 8'(i));
        cyc(0, 0, 1, 0, 8'h00);

        // Reset mid-operation with a pop in flight.
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 8'h30 + 8'(i));
        cyc(0, 0, 1, 0, 8'h00);
        chk("pre_rst_cnt", fctl_cnt, 5);
        cyc(1, 0, 1, 0, 8'h00);
        chk("mid_rst_cnt",   fctl_cnt,   0);
        chk("mid_rst_empty", fctl_empty, 1);
        chk("mid_rst_rvld",  fctl_rvld,  0);
        cyc(0, 0, 0, 0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
